// File: rtl/bptt_rev_reader_pkg.sv
// Shared types and constant helpers for the reverse-time history reader.
package bptt_rev_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Index width; a single-timestep history still needs one bit.
  function automatic int calc_t_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bptt_rev_reader_slice_mux.sv
// Selects one WIDTH-bit slice from a flat bus; yields zero when disabled or sel is out of range.
module bptt_rev_reader_slice_mux #(
  parameter int NUM_ITERATIONS = 8,
  parameter int WIDTH          = 32,
  parameter int SEL_W          = 3
) (
  input  logic [NUM_ITERATIONS*WIDTH-1:0] bus,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            en,
  output logic [WIDTH-1:0]                y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_ITERATIONS; k++) begin
      if (en && (sel == SEL_W'(k))) begin
        y = bus[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bptt_rev_reader.sv
// Snapshots the LSTM history bus on start and replays it newest-to-oldest,
// one element (plus its predecessor) per accepted beat.
module bptt_rev_reader
  import bptt_rev_reader_pkg::*;
#(
  parameter  int NUM_ITERATIONS = 8,
  parameter  int WIDTH          = 32,
  localparam int T_W            = calc_t_w(NUM_ITERATIONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ITERATIONS*WIDTH-1:0] i,
  output logic                            busy,
  output logic [WIDTH-1:0]                o,
  output logic [WIDTH-1:0]                o_prev,
  output logic [T_W-1:0]                  o_t,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic                            o_last,
  output logic                            done,
  output logic [1:0]                      dbg_state
);

  // Stream handshake: a beat transfers on any clock edge where o_valid and
  // o_ready are both high. Once raised, o_valid stays high and o/o_prev/o_t/
  // o_last stay stable until that transfer; o_ready is ignored outside RUN.

  state_t                          state;
  state_t                          state_nxt;
  logic [NUM_ITERATIONS*WIDTH-1:0] snap;
  logic [T_W-1:0]                  idx;
  logic [T_W-1:0]                  prev_sel;
  logic                            prev_en;
  logic                            accept;

  assign accept    = o_valid & o_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && (idx == '0)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    o_valid = (state == ST_RUN);
    o_last  = (state == ST_RUN) && (idx == '0);
    done    = (state == ST_DONE);
  end

  // The snapshot is only loaded from IDLE, so the upstream shifter may keep
  // moving while a replay is in flight. The decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      idx  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      snap <= i;
      idx  <= T_W'(NUM_ITERATIONS - 1);
    end else if ((state == ST_RUN) && accept && (idx != '0)) begin
      idx <= idx - 1'b1;
    end
  end

  assign o_t      = idx;
  assign prev_sel = idx - 1'b1;
  assign prev_en  = (idx != '0);

  bptt_rev_reader_slice_mux #(
    .NUM_ITERATIONS(NUM_ITERATIONS),
    .WIDTH         (WIDTH),
    .SEL_W         (T_W)
  ) u_cur_mux (
    .bus(snap),
    .sel(idx),
    .en (1'b1),
    .y  (o)
  );

  bptt_rev_reader_slice_mux #(
    .NUM_ITERATIONS(NUM_ITERATIONS),
    .WIDTH         (WIDTH),
    .SEL_W         (T_W)
  ) u_prev_mux (
    .bus(snap),
    .sel(prev_sel),
    .en (prev_en),
    .y  (o_prev)
  );

endmodule

// File: tb/tb_bptt_rev_reader.sv
// Scoreboard bench for bptt_rev_reader: an N=4/W=8 instance under randomized
// traffic and backpressure, plus an N=1/W=32 instance for the single-beat case.
module tb_bptt_rev_reader;

  localparam int NA = 4;
  localparam int WA = 8;
  localparam int NB = 1;
  localparam int WB = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_a;
  logic [NA*WA-1:0]  i_a;
  logic              busy_a;
  logic [WA-1:0]     o_a;
  logic [WA-1:0]     o_prev_a;
  logic [1:0]        o_t_a;
  logic              o_valid_a;
  logic              o_ready_a;
  logic              o_last_a;
  logic              done_a;
  logic [1:0]        dbg_a;

  logic              start_b;
  logic [NB*WB-1:0]  i_b;
  logic              busy_b;
  logic [WB-1:0]     o_b;
  logic [WB-1:0]     o_prev_b;
  logic [0:0]        o_t_b;
  logic              o_valid_b;
  logic              o_ready_b;
  logic              o_last_b;
  logic              done_b;
  logic [1:0]        dbg_b;

  bptt_rev_reader #(.NUM_ITERATIONS(NA), .WIDTH(WA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .i(i_a), .busy(busy_a),
    .o(o_a), .o_prev(o_prev_a), .o_t(o_t_a), .o_valid(o_valid_a),
    .o_ready(o_ready_a), .o_last(o_last_a), .done(done_a), .dbg_state(dbg_a)
  );

  bptt_rev_reader #(.NUM_ITERATIONS(NB), .WIDTH(WB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .i(i_b), .busy(busy_b),
    .o(o_b), .o_prev(o_prev_b), .o_t(o_t_b), .o_valid(o_valid_b),
    .o_ready(o_ready_b), .o_last(o_last_b), .done(done_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];   // {o, o_prev, o_t, o_last}
  int done_cnt_a = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: newest timestep first, predecessor is the next-older slice.
  task automatic model_push(input logic [NA*WA-1:0] d);
    logic [WA-1:0] cur;
    logic [WA-1:0] prv;
    for (int t = NA - 1; t >= 0; t--) begin
      cur = d[t*WA +: WA];
      prv = '0;
      if (t > 0) prv = d[(t-1)*WA +: WA];
      exp_q.push_back({cur, prv, 2'(t), (t == 0)});
    end
  endtask

  // ---------------- monitor ----------------
  bit          prev_stall = 0;
  bit          prev_done = 0;
  bit          prev_last_acc = 0;
  logic [19:0] prev_view = '0;

  always @(negedge clk) begin
    logic [19:0] view;
    logic [18:0] exp;
    view = {o_a, o_prev_a, o_t_a, o_last_a, o_valid_a};
    if (rst) begin
      prev_stall    = 0;
      prev_done     = 0;
      prev_last_acc = 0;
    end else begin
      if (prev_stall) check(view == prev_view, "hold_under_stall", view, prev_view);
      if (o_valid_a && o_ready_a) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", view, 0);
        end else begin
          exp = exp_q.pop_front();
          check({o_a, o_prev_a, o_t_a, o_last_a} == exp, "beat", {o_a, o_prev_a, o_t_a, o_last_a}, exp);
        end
      end
      if (done_a) begin
        done_cnt_a++;
        check(prev_last_acc, "done_after_last_beat", 0, 1);
      end
      if (prev_done) check(!busy_a && !done_a, "idle_after_done", {busy_a, done_a}, 0);
      prev_stall    = o_valid_a && !o_ready_a;
      prev_done     = done_a;
      prev_last_acc = o_valid_a && o_ready_a && o_last_a;
      prev_view     = view;
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: ready high; 1: random ready, random i and stray starts; 2: three stalls on o_t=2
  task automatic replay_a(input logic [NA*WA-1:0] d, input int mode, input bit isolate,
                          output int lat);
    int cyc;
    int stalls;
    bit busy_ok;
    int dc0;
    model_push(d);
    dc0     = done_cnt_a;
    busy_ok = 1;
    stalls  = 0;
    lat     = -1;
    @(posedge clk); #1;
    i_a = d; start_a = 1'b1; o_ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 1;
    while (cyc <= 200) begin
      if (isolate && cyc == 1) begin
        i_a = '1; start_a = 1'b1;
      end else if (isolate && cyc == 2) begin
        start_a = 1'b0;
      end else if (mode == 1) begin
        i_a = $urandom;
        start_a = ($urandom_range(0, 4) == 0);
      end
      if (mode == 1) o_ready_a = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && o_valid_a && o_t_a == 2'd2 && stalls < 3) begin
        o_ready_a = 1'b0; stalls++;
      end else o_ready_a = 1'b1;
      @(negedge clk);
      if (done_a) begin
        lat = cyc;
        break;
      end
      if (!busy_a) busy_ok = 0;
      @(posedge clk); #1;
      cyc++;
    end
    check(lat >= 0, "done_seen", lat, 1);
    check(busy_ok, "busy_through_replay", busy_ok, 1);
    @(posedge clk); #1;
    start_a = 1'b0; o_ready_a = $urandom_range(0, 1);
    @(negedge clk);
    check(done_cnt_a - dc0 == 1, "single_done", done_cnt_a - dc0, 1);
    check(exp_q.size() == 0, "all_beats_seen", exp_q.size(), 0);
  endtask

  task automatic midrun_reset_a();
    int dc0;
    bit hit;
    model_push(32'h44332211);
    hit = 0;
    @(posedge clk); #1;
    i_a = 32'h44332211; start_a = 1'b1; o_ready_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_valid_a && o_t_a == 2'd1) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check(hit, "reached_22_beat", hit, 1);
    check(o_a == 8'h22, "beat_before_reset", o_a, 8'h22);
    dc0 = done_cnt_a;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check({busy_a, o_a, o_prev_a, o_t_a, o_valid_a, o_last_a, done_a} == '0, "zero_after_midrun_rst",
          {busy_a, o_a, o_prev_a, o_t_a, o_valid_a, o_last_a, done_a}, 0);
    for (int c = 0; c < 4; c++) @(posedge clk);
    #1;
    check(done_cnt_a == dc0, "no_done_after_abort", done_cnt_a - dc0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    start_a = 0; i_a = '0; o_ready_a = 0;
    start_b = 0; i_b = '0; o_ready_b = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    o_ready_a = 1'b1;   // ready high during reset and idle must not matter
    rst = 1'b0;
    @(negedge clk);
    check({busy_a, o_a, o_prev_a, o_t_a, o_valid_a, o_last_a, done_a, dbg_a} == '0, "reset_a",
          {busy_a, o_a, o_prev_a, o_t_a, o_valid_a, o_last_a, done_a}, 0);
    check({busy_b, o_b, o_prev_b, o_t_b, o_valid_b, o_last_b, done_b, dbg_b} == '0, "reset_b",
          {busy_b, o_t_b, o_valid_b, o_last_b, done_b}, 0);

    // Single-timestep instance
    @(posedge clk); #1;
    i_b = 32'hDEADBEEF; start_b = 1'b1; o_ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; i_b = '0;
    @(negedge clk);
    check(o_valid_b && o_last_b, "n1_valid_last", {o_valid_b, o_last_b}, 2'b11);
    check(o_b == 32'hDEADBEEF, "n1_o", o_b, 32'hDEADBEEF);
    check(o_prev_b == '0 && o_t_b == 1'b0, "n1_prev_t", {o_prev_b, o_t_b}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check(done_b && !o_valid_b && busy_b, "n1_done", {done_b, o_valid_b, busy_b}, 3'b101);
    @(posedge clk); #1;
    @(negedge clk);
    check(!busy_b && !done_b, "n1_idle", {busy_b, done_b}, 0);

    // Basic replay and latency
    replay_a(32'h44332211, 0, 0, lat);
    check(lat == NA + 1, "latency_basic", lat, NA + 1);
    // Backpressure: three stall cycles on the 33 beat
    replay_a(32'h44332211, 2, 0, lat);
    check(lat == NA + 4, "latency_stall", lat, NA + 4);
    // Snapshot isolation with a start pulse during RUN
    replay_a(32'h44332211, 0, 1, lat);
    check(lat == NA + 1, "latency_isolate", lat, NA + 1);
    // Abort mid-run, then a fresh replay
    midrun_reset_a();
    replay_a(32'h44332211, 0, 0, lat);
    check(lat == NA + 1, "latency_after_rst", lat, NA + 1);
    // Signed extremes
    replay_a(32'h807FFF01, 0, 0, lat);
    // Randomized traffic
    for (int n = 0; n < 15; n++) replay_a($urandom, 1, 0, lat);

    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bptt_rev_reader.md
Name: bptt_rev_reader

Overview:
- Consumes the flat per-timestep history bus produced by the LSTM shift register and replays it one element per beat in reverse time order (t = NUM_ITERATIONS-1 down to 0) for backpropagation-through-time.
- Snapshots the history on a start pulse, so the upstream shift register may continue shifting afterwards.
- Presents the current element h_t and its predecessor h_{t-1} on a valid/ready stream, then pulses done.

Parameters:
- NUM_ITERATIONS, 8, number of timesteps held in the history bus; must be >= 1
- WIDTH, 32, signed element width in bits

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request a new replay; honoured only while idle
- i  input  NUM_ITERATIONS*WIDTH  flat signed history; slice k = i[(k+1)*WIDTH-1 : k*WIDTH] holds timestep k (slice 0 oldest, top slice newest)
- busy  output  1  high whenever the FSM is not in IDLE
- o  output  WIDTH  signed element for timestep o_t
- o_prev  output  WIDTH  signed element for timestep o_t-1; zero when o_t = 0
- o_t  output  T_W  current timestep index; T_W = max(1, clog2(NUM_ITERATIONS))
- o_valid  output  1  stream valid
- o_ready  input  1  downstream ready
- o_last  output  1  high with o_valid on the beat where o_t = 0
- done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (synchronous, rst sampled at posedge clk):
  - state IDLE; snapshot register and index cleared to 0.
  - All outputs 0: busy, o, o_prev, o_t, o_valid, o_last, done.
  - Reset overrides every other input in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_valid = 0.
  - If start = 1 at a clock edge: snapshot <= i, o_t <= NUM_ITERATIONS-1, next state RUN.
  - Otherwise remain in IDLE.
- RUN:
  - o_valid = 1.
  - o = snapshot slice o_t; o_prev = snapshot slice o_t-1, or 0 when o_t = 0.
  - o_last = (o_t == 0).
  - Beat accepted when o_valid & o_ready:
    - if o_t == 0: next state DONE;
    - else o_t decrements by 1.
  - No acceptance: o, o_prev, o_t and o_last hold stable (AXI-style; valid is never withdrawn).
- DONE:
  - done = 1 for exactly this one cycle; o_valid = 0.
  - Next state IDLE unconditionally.
- busy = (state != IDLE).
- o and o_prev are combinational muxes of the registered snapshot and index. They are glitch-free relative to the clock edge; there is no combinational path from i to any output.
- Latency, with o_ready held high and start accepted at edge k:
  - beats at cycles k+1 .. k+NUM_ITERATIONS;
  - done at cycle k+NUM_ITERATIONS+1;
  - next start honoured at the edge ending cycle k+NUM_ITERATIONS+2.
  - Each cycle of o_ready low adds one cycle.
- Boundary conditions:
  - start while busy (RUN or DONE) is ignored; the snapshot is unchanged.
  - Changes on i after the start edge have no effect on the replay in progress.
  - NUM_ITERATIONS = 1: a single beat with o_t = 0, o_last = 1, o_prev = 0.
  - Index wrap never occurs; the decrement is blocked at 0.
  - rst mid-RUN: replay aborts, no done pulse, and all outputs read 0 in the next cycle.
  - o_ready has no effect outside RUN.
- Arithmetic: none. Elements pass through bit-exact; signedness is preserved.

Decomposition:
- Shared header/package:
  - a clog2 constant function;
  - the T_W derivation;
  - state encodings IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- One sub-module, slice_mux: parameterised (NUM_ITERATIONS, WIDTH). It selects slice sel from the flat bus and returns zero when sel is out of range. It is instantiated twice, for o (sel = o_t) and for o_prev (sel = o_t-1, zero-forced at o_t = 0).

Test Plan:
- Basic replay (N=4, W=8): i = {8'h44,8'h33,8'h22,8'h11}, start for 1 cycle, o_ready = 1.
  -> o = 44,33,22,11; o_prev = 33,22,11,00; o_t = 3,2,1,0; o_last only on the 11 beat; done pulses exactly once, one cycle after that beat; busy low one cycle later.
- Backpressure: same stimulus, o_ready low for 3 cycles on the 33 beat.
  -> o = 33 and o_t = 2 held stable with o_valid = 1 for all 3 cycles; the sequence completes unchanged; done arrives 3 cycles later than in the basic case.
- Snapshot isolation: after the start edge, change i to all 8'hFF and pulse start again during RUN.
  -> the stream still outputs 44,33,22,11; exactly one done pulse; busy stays high through the replay.
- Mid-run reset: assert rst on the 22 beat.
  -> the next cycle shows o_valid = 0, busy = 0, o = o_prev = o_t = 0; no done pulse; a fresh start then replays correctly.
- Signed extremes: i = {8'h80,8'h7F,8'hFF,8'h01}.
  -> o = 80,7F,FF,01 and o_prev = 7F,FF,01,00, bit-exact.
- N=1, W=32: i = 32'hDEADBEEF, start.
  -> one beat with o = DEADBEEF, o_prev = 0, o_t = 0, o_last = 1; done on the next cycle.
